// File: rtl/button_pkg.sv
// Shared defaults, counter width and round-robin search for the push-button event controller.
package button_pkg;

  localparam int NUM_BTN_DEF    = 4;
  localparam int DB_COUNT_DEF   = 15;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int DB_CNT_W       = 10;
  localparam int MAX_BTN        = 8;
  localparam int MAX_ID_W       = 3;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } grant_t;

  // First requesting channel at or after ptr, wrapping modulo n.
  function automatic grant_t rr_search(input logic [MAX_BTN-1:0]  req,
                                       input logic [MAX_ID_W-1:0] ptr,
                                       input int unsigned         n);
    grant_t              g;
    int unsigned         pos;
    logic [MAX_ID_W-1:0] sel;
    g = '0;
    for (int unsigned i = 0; i < MAX_BTN; i++) begin
      pos = (32'(ptr) + i) % n;
      sel = pos[MAX_ID_W-1:0];
      if ((i < n) && !g.found && req[sel]) begin
        g.found = 1'b1;
        g.idx   = sel;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, press debounce counter, stable level and press pulse.
module debounce_channel
  import button_pkg::*;
#(
  parameter int DB_COUNT = DB_COUNT_DEF
) (
  input  logic m_clock,
  input  logic m_reset,
  input  logic button,
  output logic stable,
  output logic press
);

  localparam logic [DB_CNT_W-1:0] DB_LIMIT = DB_CNT_W'(DB_COUNT);

  logic                sync_p0;
  logic                sync_p1;
  logic [DB_CNT_W-1:0] cnt;
  logic                stable_d;

  // Release is not debounced: a single low synced sample drops the level.
  always_ff @(posedge m_clock or posedge m_reset) begin
    if (m_reset) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      cnt      <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      sync_p0  <= button;
      sync_p1  <= sync_p0;
      stable_d <= stable;
      if (!sync_p1) begin
        cnt    <= '0;
        stable <= 1'b0;
      end else if (cnt == DB_LIMIT) begin
        stable <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = stable & ~stable_d;

endmodule

// File: rtl/button_event_ctrl.sv
// Debounces NUM_BTN buttons, arbitrates press events round-robin into an event FIFO
// that the game logic drains through a valid/ready handshake.
module button_event_ctrl
  import button_pkg::*;
#(
  parameter int NUM_BTN    = NUM_BTN_DEF,
  parameter int DB_COUNT   = DB_COUNT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ID_W       = $clog2(NUM_BTN)
) (
  input  logic               m_clock,
  input  logic               m_reset,
  input  logic [NUM_BTN-1:0] m_button,
  output logic [NUM_BTN-1:0] m_btn_state,
  output logic               m_evt_valid,
  output logic [ID_W-1:0]    m_evt_id,
  input  logic               m_evt_ready,
  output logic               m_overflow,
  input  logic               m_clr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [NUM_BTN-1:0] stable;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] grant_mask;
  logic [MAX_BTN-1:0] req;
  grant_t             grant;
  logic               push;
  logic               pop;
  logic               drop;
  logic [ID_W-1:0]    rr;
  logic [ID_W-1:0]    rr_nxt;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [ID_W-1:0]    mem [FIFO_DEPTH];

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    debounce_channel #(.DB_COUNT(DB_COUNT)) u_chan (
      .m_clock (m_clock),
      .m_reset (m_reset),
      .button  (m_button[i]),
      .stable  (stable[i]),
      .press   (press[i])
    );
  end

  // Grant only when the registered count shows room; a same-cycle pop does not count.
  always_comb begin
    req                = '0;
    req[NUM_BTN-1:0]   = pending;
    grant              = rr_search(req, MAX_ID_W'(rr), NUM_BTN);
    push               = grant.found && (count < CW'(FIFO_DEPTH));
    grant_mask         = push ? (NUM_BTN'(1) << grant.idx) : '0;
    rr_nxt             = ID_W'((32'(grant.idx) + 32'd1) % NUM_BTN);
    drop               = |(press & pending & ~grant_mask);
    pop                = m_evt_valid & m_evt_ready;
  end

  always_ff @(posedge m_clock or posedge m_reset) begin
    if (m_reset) begin
      pending    <= '0;
      rr         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      m_overflow <= 1'b0;
    end else begin
      pending <= (pending & ~grant_mask) | press;
      if (push) begin
        rr     <= rr_nxt;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)                m_overflow <= 1'b1;
      else if (m_clr_overflow) m_overflow <= 1'b0;
    end
  end

  always_ff @(posedge m_clock) begin
    if (push) mem[wr_ptr] <= grant.idx[ID_W-1:0];
  end

  assign m_btn_state = stable;
  assign m_evt_valid = (count != '0);
  assign m_evt_id    = m_evt_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: debounce timing, glitch rejection, round-robin order,
// full-FIFO overflow, push/pop at the same edge and asynchronous reset.
module tb_button_event_ctrl;

  localparam int NUM_BTN = 4;
  localparam int ID_W    = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_BTN-1:0] button;
  logic [NUM_BTN-1:0] btn_state;
  logic               evt_valid;
  logic [ID_W-1:0]    evt_id;
  logic               evt_ready;
  logic               overflow;
  logic               clr_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  button_event_ctrl #(
    .NUM_BTN    (4),
    .DB_COUNT   (15),
    .FIFO_DEPTH (4)
  ) dut (
    .m_clock        (clk),
    .m_reset        (rst),
    .m_button       (button),
    .m_btn_state    (btn_state),
    .m_evt_valid    (evt_valid),
    .m_evt_id       (evt_id),
    .m_evt_ready    (evt_ready),
    .m_overflow     (overflow),
    .m_clr_overflow (clr_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold a press long enough to debounce, then release and let the level settle.
  task automatic press(input logic [NUM_BTN-1:0] mask);
    button = mask;
    step(20);
    button = '0;
    step(4);
  endtask

  task automatic pop_expect(input string tag, input int id);
    check({tag, "_valid"}, 32'(evt_valid), 32'd1);
    check({tag, "_id"}, 32'(evt_id), 32'(id));
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
  endtask

  initial begin
    logic seen_state;
    logic seen_valid;
    rst          = 1'b1;
    button       = '0;
    evt_ready    = 1'b0;
    clr_overflow = 1'b0;
    step(2);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_id", 32'(evt_id), 32'd0);
    check("rst_state", 32'(btn_state), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Single press on button 2: level at k+17, event visible after k+19.
    button = 4'b0100;
    step(17);
    check("t1_state_early", 32'(btn_state), 32'h0);
    step(1);
    check("t1_state_rise", 32'(btn_state), 32'h4);
    step(1);
    check("t1_valid_early", 32'(evt_valid), 32'd0);
    step(1);
    pop_expect("t1_evt", 2);
    check("t1_popped", 32'(evt_valid), 32'd0);
    button = '0;
    step(2);
    check("t1_state_hold", 32'(btn_state), 32'h4);
    step(1);
    check("t1_state_fall", 32'(btn_state), 32'h0);

    // Glitch of DB_COUNT raw cycles on button 0 must vanish.
    seen_state = 1'b0;
    seen_valid = 1'b0;
    button = 4'b0001;
    for (int i = 0; i < 40; i++) begin
      if (i == 15) button = '0;
      step(1);
      seen_state |= btn_state[0];
      seen_valid |= evt_valid;
    end
    check("glitch_state", 32'(seen_state), 32'd0);
    check("glitch_valid", 32'(seen_valid), 32'd0);

    // Move rr to 2, then simultaneous presses on 0,1,3 drain as 3,0,1.
    press(4'b0010);
    pop_expect("rr_move", 1);
    press(4'b1011);
    pop_expect("sim_a", 3);
    pop_expect("sim_b", 0);
    pop_expect("sim_c", 1);
    check("sim_empty", 32'(evt_valid), 32'd0);

    // Fill FIFO with 2,3,0,0 then press button 1 twice while full.
    press(4'b1101);
    press(4'b0001);
    press(4'b0010);
    check("full_ovf0", 32'(overflow), 32'd0);
    check("full_head", 32'(evt_id), 32'd2);
    press(4'b0010);
    check("full_ovf1", 32'(overflow), 32'd1);
    pop_expect("full_pop", 2);
    step(2);
    check("full_ovf_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    check("full_ovf_clr", 32'(overflow), 32'd0);
    pop_expect("full_d0", 3);
    pop_expect("full_d1", 0);
    pop_expect("full_d2", 0);
    pop_expect("full_d3", 1);
    check("full_empty", 32'(evt_valid), 32'd0);

    // Count 2 (ids 2,3), then pop and push (id 0) on the same edge.
    press(4'b1100);
    button = 4'b0001;
    step(19);
    check("pp_head_before", 32'(evt_id), 32'd2);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    button    = '0;
    check("pp_valid", 32'(evt_valid), 32'd1);
    check("pp_head_after", 32'(evt_id), 32'd3);
    step(4);
    pop_expect("pp_d0", 3);
    pop_expect("pp_d1", 0);
    check("pp_empty", 32'(evt_valid), 32'd0);

    // Reset with three queued events and one pending press.
    button = 4'hF;
    step(22);
    check("mr_valid_before", 32'(evt_valid), 32'd1);
    check("mr_head_before", 32'(evt_id), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mr_valid", 32'(evt_valid), 32'd0);
    check("mr_id", 32'(evt_id), 32'd0);
    check("mr_state", 32'(btn_state), 32'd0);
    check("mr_ovf", 32'(overflow), 32'd0);
    button = '0;
    step(2);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      seen_valid |= evt_valid;
    end
    check("mr_no_events", 32'(seen_valid), 32'd0);
    press(4'b0100);
    pop_expect("mr_fresh", 2);
    check("mr_empty", 32'(evt_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
# button_event_ctrl

Input controller for the stacker board's push-buttons. It synchronizes and debounces NUM_BTN raw button inputs and turns each clean press into a single event. When several presses arrive together, it arbitrates them round-robin into a small event FIFO. Game logic pops events through a valid/ready handshake. The block sits between the board pins and the game state machine, replacing ad-hoc per-button debounce instances.

## Interface
- NUM_BTN, 4: number of button channels (2..8).
- DB_COUNT, 15: stable-high count before a press is accepted (1..1023).
- FIFO_DEPTH, 4: event FIFO entries (power of two, ≥2).
- ID_W, $clog2(NUM_BTN): event id width.
- m_clock  in  1  system clock; all state on its rising edge.
- m_reset  in  1  asynchronous, active-high reset.
- m_button  in  NUM_BTN  raw, asynchronous button levels (1 = pressed).
- m_btn_state  out  NUM_BTN  debounced level per button.
- m_evt_valid  out  1  FIFO non-empty; head event presented.
- m_evt_id  out  ID_W  button index of head event.
- m_evt_ready  in  1  consumer accepts head event.
- m_overflow  out  1  sticky: at least one press was dropped.
- m_clr_overflow  in  1  synchronous clear of m_overflow.

## Operation
- Reset values:
  - Sync flops, counters, m_btn_state, pending bits, FIFO pointers and count are all 0.
  - The round-robin pointer is 0.
  - m_evt_valid = 0, m_evt_id = 0, m_overflow = 0.
- Per channel:
  - The raw input passes through a 2-flop synchronizer.
  - While the synced level is 1, the 10-bit counter increments each cycle. When the counter reaches DB_COUNT, stable is set to 1 and the counter holds; it does not wrap.
  - When the synced level is 0, stable and the counter clear on the next edge. There is no release debounce.
- Press event: the rising edge of stable (stable & ~stable_d). The event sets the channel's pending bit.
- If a press event occurs while the channel's pending bit is already 1, the press is dropped and m_overflow is set.
- Arbiter:
  - Each cycle, if any pending bit is set and FIFO count < FIFO_DEPTH, grant the first pending channel at or after the rr pointer (wrapping).
  - Push the granted index, clear its pending bit, and set rr = grant+1 mod NUM_BTN.
  - At most one grant per cycle.
- A press event and a grant on the same channel in the same cycle: grant clears the old pending, the new press sets it again, and there is no overflow.
- Full FIFO: no grant, pending bits wait, nothing is lost unless a channel re-presses (overflow rule above).
- Push is decided on the registered count only. A same-cycle pop does not free a slot for a push.
- Pop: m_evt_valid & m_evt_ready advances the read pointer. m_evt_ready while empty is ignored.
- Push and pop in the same cycle leave the count unchanged.
- m_clr_overflow clears m_overflow. If a drop occurs in the same cycle, set wins.
- m_reset asserted mid-operation: all state returns to reset values immediately, and queued events are discarded.

## Timing
- Raw high first sampled at edge k:
  - Synced level is 1 after k+1.
  - m_btn_state rises at edge k+DB_COUNT+2.
  - Pending is set at k+DB_COUNT+3.
  - FIFO push occurs at k+DB_COUNT+4, with m_evt_valid = 1 after that edge (no contention, FIFO not full).
- A raw glitch shorter than DB_COUNT+1 synced cycles produces no state change and no event.
- m_evt_id is stable while m_evt_valid = 1 and not popped.
- Throughput: one push and one pop per cycle.
- m_btn_state falls 2 edges after raw falls.

## Structure
- Shared package button_pkg holds:
  - Defaults for NUM_BTN, DB_COUNT and FIFO_DEPTH.
  - A counter width constant DB_CNT_W = 10.
  - A function for the round-robin next-grant search.
- Sub-module debounce_channel contains the synchronizer, counter, stable flag and press pulse; it is instantiated NUM_BTN times.
- The arbiter and FIFO (register array, read and write pointers, count of width $clog2(FIFO_DEPTH)+1) stay in the top.

## Test plan
- Reset then single press: DB_COUNT=15, button 2 raw high from edge 10, ready held 0.
  - m_btn_state[2] rises at edge 27.
  - m_evt_valid rises after edge 29 with id 2.
  - ready pulse pops it, and valid drops.
- Glitch rejection: button 0 high for 10 cycles, then low.
  - No m_btn_state change, no event.
- Simultaneous presses: buttons 0, 1, 3 reach stable in the same cycle, rr pointer at 2.
  - FIFO order is 3, 0, 1 on consecutive cycles.
- Full FIFO and overflow: FIFO_DEPTH=4 filled, ready=0.
  - Button 1 press keeps pending.
  - A second button 1 press sets m_overflow.
  - After 1 pop, id 1 is pushed once.
  - m_clr_overflow clears the flag.
- Simultaneous push/pop at count 2: count stays 2 and ordering is preserved.
- Mid-operation reset: m_reset asserted with 3 queued events and pending bits set.
  - All outputs return to 0 asynchronously.
  - No events appear after release until a fresh debounced press.
